// File: rtl/dco_loop_filter.sv
// PI loop filter and NCO for the clock-recovery PLL: phase_detector up/down in, vco_clk/locked out.
// Optional DCO_FREQ_OVERRIDE_EN adds ovr_en/ovr_word to open the loop with a forced increment.
module dco_loop_filter #(
   parameter int              ACC_W      = 16,
   parameter logic [ACC_W-1:0] NOM_FREQ  = 16'h1000,
   parameter int              INT_W      = 12,
   parameter int              INT_LIM    = 2047,
   parameter int              KP_SH      = 2,
   parameter int              KI_SH      = 4,
   parameter int              LOCK_CNT   = 64,
   parameter int              LOCK_TOL   = 2,
   parameter int              UNLOCK_TOL = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             up,
   input  logic             down,
`ifdef DCO_FREQ_OVERRIDE_EN
   input  logic             ovr_en,
   input  logic [ACC_W-1:0] ovr_word,
`endif
   output logic             vco_clk,
   output logic             locked,
   output logic [ACC_W-1:0] freq_word
);

   localparam int SW  = ACC_W + 2;
   localparam int LCW = $clog2(LOCK_CNT + 1);
   localparam logic signed [INT_W:0]  LIM_POS    = (INT_W+1)'(INT_LIM);
   localparam logic signed [INT_W:0]  LIM_NEG    = -LIM_POS;
   localparam logic signed [SW-1:0]   FW_MIN     = SW'(1);
   localparam logic signed [SW-1:0]   FW_MAX     = SW'((2**(ACC_W-1)) - 1);
   localparam logic [7:0]             LOCK_TOL_V = 8'(LOCK_TOL);
   localparam logic [7:0]             UNLK_TOL_V = 8'(UNLOCK_TOL);
   localparam logic [LCW-1:0]         LOCK_CNT_V = LCW'(LOCK_CNT);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   state_t                  state_reg, state_next;
   logic [LCW-1:0]          lock_cnt_reg, lock_cnt_next, lock_cnt_inc;
   logic                    locked_reg, locked_next;
   logic                    up_meta_reg, up_s_reg, down_meta_reg, down_s_reg;
   logic signed [1:0]       err_reg, err_next;
   logic signed [INT_W-1:0] integ_reg, integ_next;
   logic signed [INT_W:0]   integ_sum;
   logic signed [SW-1:0]    integ_ext, err_ext, integ_term, err_term, fw_sum;
   logic [ACC_W-1:0]        freq_word_reg, fw_next;
   logic [ACC_W-1:0]        acc_reg;
   logic                    vco_clk_reg, vco_rise, idle_now;
   logic [7:0]              perr_reg, perr_next;

   always_comb begin
      err_next = 2'sd0;
      if (up_s_reg && !down_s_reg)
         err_next = 2'sd1;
      else if (down_s_reg && !up_s_reg)
         err_next = -2'sd1;
   end

   // Integrator saturates symmetrically; the proportional path uses the raw error.
   always_comb begin
      integ_sum = {integ_reg[INT_W-1], integ_reg} + {{(INT_W-1){err_reg[1]}}, err_reg};
      if (integ_sum > LIM_POS)
         integ_next = LIM_POS[INT_W-1:0];
      else if (integ_sum < LIM_NEG)
         integ_next = LIM_NEG[INT_W-1:0];
      else
         integ_next = integ_sum[INT_W-1:0];
`ifdef DCO_FREQ_OVERRIDE_EN
      if (ovr_en)
         integ_next = integ_reg;
`endif
      integ_ext  = {{(SW-INT_W){integ_next[INT_W-1]}}, integ_next};
      err_ext    = {{(SW-2){err_reg[1]}}, err_reg};
      integ_term = integ_ext >>> KI_SH;
      err_term   = err_ext <<< KP_SH;
      fw_sum     = $signed({2'b00, NOM_FREQ}) + integ_term + err_term;
`ifdef DCO_FREQ_OVERRIDE_EN
      if (ovr_en)
         fw_sum = $signed({2'b00, ovr_word});
`endif
      // Keep vco_clk between clk/2 and a non-zero rate.
      if (fw_sum < FW_MIN)
         fw_next = FW_MIN[ACC_W-1:0];
      else if (fw_sum > FW_MAX)
         fw_next = FW_MAX[ACC_W-1:0];
      else
         fw_next = fw_sum[ACC_W-1:0];
   end

   assign vco_rise = acc_reg[ACC_W-1] & ~vco_clk_reg;
   assign idle_now = !enable || (state_reg == IDLE);

   // The rise cycle's own error starts the next period's count.
   always_comb begin
      perr_next = perr_reg;
      if (vco_rise)
         perr_next = {7'd0, err_reg != 2'sd0};
      else if (err_reg != 2'sd0 && perr_reg != 8'hFF)
         perr_next = perr_reg + 8'd1;
   end

   always_comb begin
      state_next    = state_reg;
      lock_cnt_next = lock_cnt_reg;
      locked_next   = locked_reg;
      lock_cnt_inc  = lock_cnt_reg + 1'b1;
      if (!enable) begin
         state_next    = IDLE;
         lock_cnt_next = '0;
         locked_next   = 1'b0;
      end
`ifdef DCO_FREQ_OVERRIDE_EN
      else if (ovr_en) begin
         state_next    = ACQUIRE;
         lock_cnt_next = '0;
         locked_next   = 1'b0;
      end
`endif
      else begin
         case (state_reg)
            IDLE: begin
               state_next    = ACQUIRE;
               lock_cnt_next = '0;
               locked_next   = 1'b0;
            end
            ACQUIRE: begin
               if (vco_rise) begin
                  if (perr_reg <= LOCK_TOL_V) begin
                     lock_cnt_next = lock_cnt_inc;
                     if (lock_cnt_inc == LOCK_CNT_V) begin
                        state_next  = LOCKED;
                        locked_next = 1'b1;
                     end
                  end else begin
                     lock_cnt_next = '0;
                  end
               end
            end
            LOCKED: begin
               if (vco_rise && perr_reg > UNLK_TOL_V) begin
                  state_next    = ACQUIRE;
                  locked_next   = 1'b0;
                  lock_cnt_next = '0;
               end
            end
            default: begin
               state_next    = IDLE;
               lock_cnt_next = '0;
               locked_next   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         lock_cnt_reg <= '0;
         locked_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lock_cnt_reg <= lock_cnt_next;
         locked_reg   <= locked_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_meta_reg   <= 1'b0;
         up_s_reg      <= 1'b0;
         down_meta_reg <= 1'b0;
         down_s_reg    <= 1'b0;
         err_reg       <= 2'sd0;
         acc_reg       <= '0;
         integ_reg     <= '0;
         perr_reg      <= '0;
         vco_clk_reg   <= 1'b0;
         freq_word_reg <= '0;
      end else begin
         up_meta_reg   <= up;
         up_s_reg      <= up_meta_reg;
         down_meta_reg <= down;
         down_s_reg    <= down_meta_reg;
         err_reg       <= err_next;
         if (idle_now) begin
            acc_reg       <= '0;
            integ_reg     <= '0;
            perr_reg      <= '0;
            vco_clk_reg   <= 1'b0;
            freq_word_reg <= NOM_FREQ;
         end else begin
            acc_reg       <= acc_reg + freq_word_reg;
            vco_clk_reg   <= acc_reg[ACC_W-1];
            integ_reg     <= integ_next;
            perr_reg      <= perr_next;
            freq_word_reg <= fw_next;
         end
      end
   end

   assign vco_clk   = vco_clk_reg;
   assign locked    = locked_reg;
   assign freq_word = freq_word_reg;

endmodule

// File: tb/tb_dco_loop_filter.sv
// Scoreboard bench for dco_loop_filter: directed stimulus queues expectations, a negedge monitor checks them.
// Define DCO_FREQ_OVERRIDE_EN to also exercise the override ports.
module tb_dco_loop_filter;

   localparam int K_CYC  = 0;  // due = cycle count
   localparam int K_RISE = 1;  // due = vco_clk rising-edge count
   localparam int S_FW = 0, S_LOCK = 1, S_VCO = 2, S_PER = 3, S_HIGH = 4;

   typedef struct packed {
      int kind;
      int due;
      int sig;
      int tag;
      int exp;
   } chk_t;

   logic        clk, rst, enable, up, down;
   logic        vco_clk, locked;
   logic [15:0] freq_word;
`ifdef DCO_FREQ_OVERRIDE_EN
   logic        ovr_en;
   logic [15:0] ovr_word;
`endif

   chk_t sb[$];
   int   cyc = 0;
   int   rise_total = 0;
   int   last_rise = -1;
   int   period_meas = -1;
   int   high_meas = -1;
   int   tests = 0;
   int   fails = 0;

   dco_loop_filter dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .up        (up),
      .down      (down),
`ifdef DCO_FREQ_OVERRIDE_EN
      .ovr_en    (ovr_en),
      .ovr_word  (ovr_word),
`endif
      .vco_clk   (vco_clk),
      .locked    (locked),
      .freq_word (freq_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic string sig_name(input int s);
      case (s)
         S_FW:    return "freq_word";
         S_LOCK:  return "locked";
         S_VCO:   return "vco_clk";
         S_PER:   return "vco_period";
         default: return "vco_high";
      endcase
   endfunction

   task automatic expect_at(input int kind, input int due, input int sig, input int val, input int tag);
      chk_t c;
      c.kind = kind; c.due = due; c.sig = sig; c.tag = tag; c.exp = val;
      sb.push_back(c);
   endtask

   // Monitor: tracks vco_clk edges and compares queued expectations as they fall due.
   initial begin
      logic vco_prev;
      chk_t c;
      int   act;
      vco_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (vco_clk === 1'b1 && vco_prev === 1'b0) begin
            rise_total++;
            if (last_rise >= 0) period_meas = cyc - last_rise;
            last_rise = cyc;
         end
         if (vco_clk === 1'b0 && vco_prev === 1'b1 && last_rise >= 0)
            high_meas = cyc - last_rise;
         vco_prev = vco_clk;
         while (sb.size() > 0 &&
                ((sb[0].kind == K_CYC && cyc >= sb[0].due) ||
                 (sb[0].kind == K_RISE && rise_total >= sb[0].due))) begin
            c = sb.pop_front();
            case (c.sig)
               S_FW:    act = int'(freq_word);
               S_LOCK:  act = int'(locked);
               S_VCO:   act = int'(vco_clk);
               S_PER:   act = period_meas;
               default: act = high_meas;
            endcase
            tests++;
            if (act !== c.exp) begin
               fails++;
               $display("FAIL case%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                        c.tag, sig_name(c.sig), act, c.exp, cyc);
            end else begin
               $display("[TB] case%0d %s = 0x%0h ok (cycle %0d)", c.tag, sig_name(c.sig), act, cyc);
            end
         end
      end
   end

   task automatic wait_rises(input int target, input int limit, input int tag);
      int n;
      n = 0;
      while (rise_total < target && n < limit) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (rise_total < target) begin
         tests++;
         fails++;
         $display("FAIL case%0d rise_wait: got %0d rises, expected %0d", tag, rise_total, target);
      end
   endtask

   initial begin
      int t0;
      int base;
      int u;
      int n;
      rst = 1'b1; enable = 1'b0; up = 1'b0; down = 1'b0;
`ifdef DCO_FREQ_OVERRIDE_EN
      ovr_en = 1'b0; ovr_word = 16'h0000;
`endif
      // Reset values, then IDLE drives the nominal word.
      expect_at(K_CYC, 2, S_FW, 0, 0);
      expect_at(K_CYC, 2, S_LOCK, 0, 0);
      expect_at(K_CYC, 2, S_VCO, 0, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      expect_at(K_CYC, cyc + 3, S_FW, 'h1000, 0);

      // Case 1: free-running at clk/16, 50% duty.
      repeat (5) @(posedge clk);
      #1 enable = 1'b1;
      repeat (120) @(posedge clk);
      #1;
      expect_at(K_CYC, cyc + 1, S_FW, 'h1000, 1);
      expect_at(K_CYC, cyc + 1, S_PER, 16, 1);
      expect_at(K_CYC, cyc + 1, S_HIGH, 8, 1);

      // Case 2: up held 100 clk, err reaches integ three cycles after input.
      @(posedge clk);
      #1 up = 1'b1;
      t0 = cyc;
      expect_at(K_CYC, t0 + 4,   S_FW, 'h1004, 2);
      expect_at(K_CYC, t0 + 20,  S_FW, 'h1005, 2);
      expect_at(K_CYC, t0 + 100, S_FW, 'h100A, 2);
      expect_at(K_CYC, t0 + 104, S_FW, 'h1006, 2);
      expect_at(K_CYC, t0 + 150, S_FW, 'h1006, 2);
      repeat (100) @(posedge clk);
      #1 up = 1'b0;
      repeat (60) @(posedge clk);

      // Case 3: down held 3000 clk from integ=100, saturating at -2047.
      #1 down = 1'b1;
      t0 = cyc;
      expect_at(K_CYC, t0 + 4,    S_FW, 'h1002, 3);
      expect_at(K_CYC, t0 + 103,  S_FW, 'h0FFC, 3);
      expect_at(K_CYC, t0 + 104,  S_FW, 'h0FFB, 3);
      expect_at(K_CYC, t0 + 2500, S_FW, 'h0F7C, 3);
      expect_at(K_CYC, t0 + 3010, S_FW, 'h0F80, 3);
      repeat (3000) @(posedge clk);
      #1 down = 1'b0;
      repeat (20) @(posedge clk);

      // Case 4: overlapping up/down is zero error.
      #1 up = 1'b1; down = 1'b1;
      t0 = cyc;
      expect_at(K_CYC, t0 + 10, S_FW, 'h0F80, 4);
      expect_at(K_CYC, t0 + 50, S_FW, 'h0F80, 4);
      expect_at(K_CYC, t0 + 60, S_FW, 'h0F80, 4);
      repeat (50) @(posedge clk);
      #1 up = 1'b0; down = 1'b0;
      repeat (15) @(posedge clk);

      // Case 5: disable clears the loop; lock on the 64th rise; 5-clk up pulse unlocks.
      #1 enable = 1'b0;
      t0 = cyc;
      expect_at(K_CYC, t0 + 2, S_FW, 'h1000, 5);
      expect_at(K_CYC, t0 + 2, S_LOCK, 0, 5);
      expect_at(K_CYC, t0 + 2, S_VCO, 0, 5);
      repeat (4) @(posedge clk);
      #1 enable = 1'b1;
      base = rise_total;
      expect_at(K_RISE, base + 63, S_LOCK, 0, 5);
      expect_at(K_RISE, base + 64, S_LOCK, 1, 5);
      wait_rises(base + 64, 1500, 5);
      u = rise_total + 1;
      expect_at(K_RISE, u, S_LOCK, 0, 5);
      expect_at(K_RISE, u + 64, S_LOCK, 1, 5);
      @(posedge clk);
      #1 up = 1'b1;
      repeat (5) @(posedge clk);
      #1 up = 1'b0;
      wait_rises(u + 64, 1500, 5);

      // Case 6: asynchronous reset while locked, then relock.
      @(posedge clk);
      #2 rst = 1'b1;
      expect_at(K_CYC, cyc, S_FW, 0, 6);
      expect_at(K_CYC, cyc, S_LOCK, 0, 6);
      expect_at(K_CYC, cyc, S_VCO, 0, 6);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      base = rise_total;
      expect_at(K_RISE, base + 63, S_LOCK, 0, 6);
      expect_at(K_RISE, base + 64, S_LOCK, 1, 6);
      wait_rises(base + 64, 1500, 6);

`ifdef DCO_FREQ_OVERRIDE_EN
      // Case 7: override word, clamping at both ends, then loop resumes.
      @(posedge clk);
      #1 ovr_en = 1'b1; ovr_word = 16'h2000;
      t0 = cyc;
      expect_at(K_CYC, t0 + 3, S_FW, 'h2000, 7);
      expect_at(K_CYC, t0 + 3, S_LOCK, 0, 7);
      repeat (60) @(posedge clk);
      #1;
      expect_at(K_CYC, cyc + 1, S_PER, 8, 7);
      expect_at(K_CYC, cyc + 1, S_HIGH, 4, 7);
      @(posedge clk);
      #1 ovr_word = 16'hFFFF;
      expect_at(K_CYC, cyc + 3, S_FW, 'h7FFF, 7);
      repeat (5) @(posedge clk);
      #1 ovr_word = 16'h0000;
      expect_at(K_CYC, cyc + 3, S_FW, 'h0001, 7);
      repeat (5) @(posedge clk);
      #1 ovr_en = 1'b0;
      expect_at(K_CYC, cyc + 3, S_FW, 'h1000, 7);
      expect_at(K_CYC, cyc + 3, S_LOCK, 0, 7);
      repeat (5) @(posedge clk);
`endif

      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending checks, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
